pipe_hazard_ctrl: RTL

//  Central stall/flush/redirect sequencer for the 5-stage pipeline. Drives the *_Wr
//  and *_Flush strobes of PipeLineRegsInterface from cache-busy, load-use, divider,

---
 rtl/pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage pipeline.
// Arbitrates cache-busy, load-use, divider, branch and exception events into
// per-stage write/flush strobes and a single PC redirect per cycle.
module pipe_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_busy,
    input  logic        dcache_busy,
    input  logic        exe_is_load,
    input  logic [4:0]  exe_dst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        exe_div_start,
    input  logic        exe_br_taken,
    input  logic [31:0] exe_br_target,
    input  logic        mem_exc,
    input  logic        mem_eret,
    input  logic [31:0] cp0_epc,
    output logic        IF_PCWr,
    output logic        IF_IDWr,
    output logic        ID_EXEWr,
    output logic        EXE_MEMWr,
    output logic        MEM_WBWr,
    output logic        IFID_Flush,
    output logic        IDEXE_Flush,
    output logic        EXEMEM_Flush,
    output logic        MEMWB_Flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        div_busy
);

    localparam int unsigned CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_DIV = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_done_q, div_done_d;
    logic               pend_v_q, pend_v_d;
    logic [31:0]        pend_pc_q, pend_pc_d;

    logic exc;
    logic load_use;
    logic div_req;

    assign exc      = mem_exc | mem_eret;
    assign load_use = exe_is_load && (exe_dst != 5'd0) &&
                      ((id_uses_rs && (id_rs == exe_dst)) ||
                       (id_uses_rt && (id_rt == exe_dst)));
    assign div_req  = (state_q == ST_DIV) || (exe_div_start && !div_done_q);

    // Hazard arbitration, redirect selection and next-state computation.
    always_comb begin
        IF_PCWr        = 1'b1;
        IF_IDWr        = 1'b1;
        ID_EXEWr       = 1'b1;
        EXE_MEMWr      = 1'b1;
        MEM_WBWr       = 1'b1;
        IFID_Flush     = 1'b0;
        IDEXE_Flush    = 1'b0;
        EXEMEM_Flush   = 1'b0;
        MEMWB_Flush    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        div_busy       = 1'b0;
        state_d        = state_q;
        cnt_d          = cnt_q;
        div_done_d     = div_done_q;
        pend_v_d       = pend_v_q;
        pend_pc_d      = pend_pc_q;

        if (exc) begin
            IFID_Flush   = 1'b1;
            IDEXE_Flush  = 1'b1;
            EXEMEM_Flush = 1'b1;
            state_d      = ST_RUN;
            cnt_d        = '0;
            div_done_d   = 1'b0;
        end else if (dcache_busy) begin
            IF_PCWr     = 1'b0;
            IF_IDWr     = 1'b0;
            ID_EXEWr    = 1'b0;
            EXE_MEMWr   = 1'b0;
            MEMWB_Flush = 1'b1;
        end else if (div_req) begin
            IF_PCWr      = 1'b0;
            IF_IDWr      = 1'b0;
            ID_EXEWr     = 1'b0;
            EXE_MEMWr    = 1'b0;
            EXEMEM_Flush = 1'b1;
            div_busy     = 1'b1;
            // Counter only runs on cycles that actually stall for the divider
            if (state_q == ST_RUN) begin
                state_d = ST_DIV;
                cnt_d   = CNT_W'(DIV_CYCLES - 2);
            end else if (cnt_q == '0) begin
                state_d    = ST_RUN;
                div_done_d = 1'b1;
            end else begin
                cnt_d = CNT_W'(cnt_q - 1'b1);
            end
        end else if (load_use) begin
            IF_PCWr     = 1'b0;
            IF_IDWr     = 1'b0;
            IDEXE_Flush = 1'b1;
        end else if (icache_busy) begin
            IF_PCWr    = 1'b0;
            IFID_Flush = 1'b1;
        end

        // The DIV/DIVU leaving EXE re-arms the start detector
        if (EXE_MEMWr) begin
            div_done_d = 1'b0;
        end

        // Exceptions always redirect at once (IF_PCWr is 1) and drop any pending branch
        if (exc) begin
            redirect_valid = 1'b1;
            redirect_pc    = mem_exc ? EXC_VECTOR : cp0_epc;
            pend_v_d       = 1'b0;
        end else if (exe_br_taken && EXE_MEMWr) begin
            IFID_Flush = 1'b1;
            if (IF_PCWr) begin
                redirect_valid = 1'b1;
                redirect_pc    = exe_br_target;
                pend_v_d       = 1'b0;
            end else begin
                pend_v_d  = 1'b1;
                pend_pc_d = exe_br_target;
            end
        end else if (pend_v_q && IF_PCWr) begin
            redirect_valid = 1'b1;
            redirect_pc    = pend_pc_q;
            IFID_Flush     = 1'b1;
            pend_v_d       = 1'b0;
        end

        if (rst) begin
            IF_PCWr        = 1'b0;
            IF_IDWr        = 1'b0;
            ID_EXEWr       = 1'b0;
            EXE_MEMWr      = 1'b0;
            MEM_WBWr       = 1'b0;
            IFID_Flush     = 1'b1;
            IDEXE_Flush    = 1'b1;
            EXEMEM_Flush   = 1'b1;
            MEMWB_Flush    = 1'b1;
            redirect_valid = 1'b0;
            redirect_pc    = 32'd0;
            div_busy       = 1'b0;
        end
    end

    // State, divider counter and pending-redirect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            div_done_q <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_pc_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_done_q <= div_done_d;
            pend_v_q   <= pend_v_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

endmodule
